mpadd_seq: RTL
==============

# mpadd_seq

Multi-precision add/subtract sequencer. It computes a WORDS×16-bit sum or difference by time-sharing one 16-bit adder slice over WORDS cycles, carrying the slice carry-out between cycles in a register. It sits between a requester that issues wide arithmetic operations and the shared 16-bit adder datapath, and it replaces a wide combinational adder where area matters more than latency.

## Interface
- WORDS, 4, number of 16-bit words per operand; legal range 1..16; operand width W = 16*WORDS.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request pulse; sampled only in IDLE.
- sub  in  1  0 = a+b, 1 = a−b; latched with the operands.
- a  in  W  operand A; latched on start acceptance.
- b  in  W  operand B; latched on start acceptance.
- busy  out  1  high from the acceptance edge until done is asserted.
- done  out  1  one-cycle pulse: result and flags valid.
- result  out  W  sum/difference; held from done until the next acceptance.
- cout  out  1  final carry-out (for sub: 1 = no borrow).
- ovf  out  1  two's-complement signed overflow of the W-bit operation.
- zero  out  1  result == 0.

## Operation
- States: IDLE, RUN, DONE. Word counter idx is ceil(log2(WORDS+1)) bits wide. The carry register is c.
- IDLE: if start=1 at an edge, latch a, b and sub, set c=sub and idx=0, clear result, go to RUN. busy rises on that edge.
- RUN, each edge:
  - bw = b[idx] if sub=0, else ~b[idx].
  - {c, result[idx]} = a[idx] + bw + c.
  - idx increments.
  - When idx = WORDS−1 at the edge, write the last word, capture cout = final carry, compute ovf and zero, and go to DONE.
- ovf = (a_msb == bw_msb) && (sum_msb != a_msb), using the top word's bit 15.
- zero is computed over the full W-bit result, including the word written on the final edge.
- DONE: done=1 and busy=0 for one cycle, then go unconditionally to IDLE. start is ignored in DONE.
- start during RUN or DONE is ignored. No queuing; the requester must wait for done.
- Operand inputs a, b and sub may change freely after acceptance without affecting the operation in flight.
- rst_n=0 at any edge, including mid-RUN, forces IDLE and clears all outputs and internal state. No partial result is presented.
- Reset values: busy=0, done=0, result=0, cout=0, ovf=0, zero=0, idx=0, c=0.

## Timing
- Acceptance edge = E0. Word k is written at edge E0+k+1.
- done is high in the cycle following edge E0+WORDS, that is, WORDS+1 edges after start was sampled in IDLE. Latency = WORDS cycles; the done cycle is the additional cycle after them.
- Earliest next acceptance is the edge that ends the done cycle plus one IDLE cycle: start may be sampled at edge E0+WORDS+2. Throughput is one operation per WORDS+2 cycles.
- The adder slice is combinational. Its critical path is a 16-bit carry chain plus the bw inversion mux and the result/carry register setup. No W-bit carry chain exists.
- cout, ovf and zero change only at the edge entering DONE, and at reset.
- WORDS=1 degenerates to a single RUN cycle followed by done. It must still take the IDLE→RUN→DONE path.

## Test plan
- WORDS=4, sub=0, a=0x0000_FFFF_FFFF_FFFF, b=0x1 -> carry ripples across word boundaries; done at E0+5; result=0x0001_0000_0000_0000, cout=0, ovf=0, zero=0.
- WORDS=4, sub=0, a=all ones, b=0x1 -> result=0, cout=1, zero=1, ovf=0.
- WORDS=4, sub=1, a=5, b=7 -> result=0xFFFF_FFFF_FFFF_FFFE, cout=0 (borrow), ovf=0.
- WORDS=4, sub=1, a=0x8000_0000_0000_0000, b=1 -> result=0x7FFF_FFFF_FFFF_FFFF, ovf=1, cout=1.
- Edge cases, WORDS=4:
  - Pulse start again at E0+2 with different operands; it is ignored, and the first result is correct.
  - Change a/b mid-RUN; the result is unaffected.
  - Assert rst_n=0 at E0+2; all outputs are 0 next cycle, and no done occurs.
  - A new start after reset completes correctly.
- WORDS=1, sub=0, a=0xFFFF, b=0x0001 -> done at E0+2, result=0x0000, cout=1, zero=1.
- Back-to-back: start held high continuously -> operations accepted every WORDS+2 cycles, done pulses exactly one cycle each.

Source files
------------

// File: rtl/mpadd_if.sv
// Request/response bundle between a wide-arithmetic requester and mpadd_seq.
interface mpadd_if #(parameter int WORDS = 4);
   localparam int W = 16 * WORDS;

   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;
   logic         zero;

   modport master (output start, sub, a, b,
                   input  busy, done, result, cout, ovf, zero);
   modport slave  (input  start, sub, a, b,
                   output busy, done, result, cout, ovf, zero);
endinterface

// File: rtl/mpadd_seq.sv
// Multi-precision add/subtract: one 16-bit slice reused over WORDS cycles,
// with the slice carry held in a register between words.
module mpadd_seq #(
   parameter int WORDS = 4
) (
   input  logic  clk,
   input  logic  rst_n,
   mpadd_if.slave bus
);
   localparam int W  = 16 * WORDS;
   localparam int IW = $clog2(WORDS + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          c_q, c_d;
   logic          sub_q, sub_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  result_q, result_d;
   logic          cout_q, cout_d;
   logic          ovf_q, ovf_d;
   logic          zero_q, zero_d;

   logic [15:0]   a_w, bw;
   logic [16:0]   sum;
   int            widx;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      c_d      = c_q;
      sub_d    = sub_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      widx     = int'(idx_q);
      a_w      = '0;
      bw       = '0;
      sum      = '0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d      = bus.a;
               b_d      = bus.b;
               sub_d    = bus.sub;
               c_d      = bus.sub;
               idx_d    = '0;
               result_d = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            a_w = a_q[widx*16 +: 16];
            bw  = sub_q ? ~b_q[widx*16 +: 16] : b_q[widx*16 +: 16];
            sum = {1'b0, a_w} + {1'b0, bw} + {16'b0, c_q};
            result_d[widx*16 +: 16] = sum[15:0];
            c_d   = sum[16];
            idx_d = idx_q + 1'b1;
            // Flags are taken on the last word; zero sees the word written now.
            if (idx_q == IW'(WORDS - 1)) begin
               cout_d  = sum[16];
               ovf_d   = (a_w[15] == bw[15]) && (sum[15] != a_w[15]);
               zero_d  = (result_d == '0);
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         c_q      <= 1'b0;
         sub_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         c_q      <= c_d;
         sub_q    <= sub_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   assign bus.busy   = (state_q == RUN);
   assign bus.done   = (state_q == DONE);
   assign bus.result = result_q;
   assign bus.cout   = cout_q;
   assign bus.ovf    = ovf_q;
   assign bus.zero   = zero_q;
endmodule
